// File: rtl/ahb_sram16_resp_if.sv
// rtl/ahb_sram16_resp_if.sv - AHB-Lite signal bundle between initiator/decoder and the SRAM responder
interface ahb_sram16_resp_if #(
    parameter int ADDR_WIDTH = 21
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic                  HREADY;
    logic [31:0]           HWDATA;
    logic [3:0]            HWSTRB;
    logic [31:0]           HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA, HWSTRB,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA, HWSTRB,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_sram16_resp.sv
// rtl/ahb_sram16_resp.sv - AHB-Lite responder splitting 32-bit transfers into two 16-bit async SRAM accesses; optional SRAM_STRB_SKIP_EN skips write halves with no strobes
module ahb_sram16_resp #(
    parameter int ADDR_WIDTH  = 21,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    ahb_sram16_resp_if.slave      bus,
    output logic [ADDR_WIDTH-2:0] SRAM_ADDR,
    output logic [15:0]           SRAM_DQ_o,
    output logic                  SRAM_DQ_oe,
    input  logic [15:0]           SRAM_DQ_i,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_OE_N,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_UB_N,
    output logic                  SRAM_LB_N
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    // Last cycle index of an N = WAIT_STATES+1 cycle SRAM access.
    localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-3:0] word_q, word_d;
    logic                  write_q, write_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            strb_q, strb_d;
    logic [31:0]           hrdata_q, hrdata_d;
    logic                  hreadyout_q, hreadyout_d;
    logic [ADDR_WIDTH-2:0] addr_q, addr_d;
    logic [15:0]           dq_o_q, dq_o_d;
    logic                  dq_oe_q, dq_oe_d;
    logic                  ce_n_q, ce_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;
    logic                  ub_n_q, ub_n_d;
    logic                  lb_n_q, lb_n_d;

    logic accept;
    logic start_lo;
    logic start_hi;
    logic release_bus;
    logic unused_bits;

    // Byte offset and the SEQ/NONSEQ distinction carry no meaning here.
    assign unused_bits = ^{bus.HADDR[1:0], bus.HTRANS[0]};

    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        hrdata_d    = hrdata_q;
        hreadyout_d = hreadyout_q;
        addr_d      = addr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        ub_n_d      = ub_n_q;
        lb_n_d      = lb_n_q;
        start_lo    = 1'b0;
        start_hi    = 1'b0;
        release_bus = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d     = S_LATCH;
                    word_d      = bus.HADDR[ADDR_WIDTH-1:2];
                    write_d     = bus.HWRITE;
                    hreadyout_d = 1'b0;
                end else begin
                    state_d     = S_IDLE;
                    hreadyout_d = 1'b1;
                end
            end
            S_LATCH: begin
                if (write_q) begin
                    wdata_d = bus.HWDATA;
                    strb_d  = bus.HWSTRB;
                end
`ifdef SRAM_STRB_SKIP_EN
                if (write_q && (strb_d[1:0] == 2'b00)) begin
                    if (strb_d[3:2] == 2'b00) begin
                        state_d     = S_DONE;
                        hreadyout_d = 1'b1;
                    end else begin
                        state_d  = S_HI;
                        start_hi = 1'b1;
                    end
                end else begin
                    state_d  = S_LO;
                    start_lo = 1'b1;
                end
`else
                state_d  = S_LO;
                start_lo = 1'b1;
`endif
            end
            S_LO: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_CNT) begin
                    if (!write_q) begin
                        hrdata_d[15:0] = SRAM_DQ_i;
                    end
`ifdef SRAM_STRB_SKIP_EN
                    if (write_q && (strb_q[3:2] == 2'b00)) begin
                        state_d     = S_DONE;
                        hreadyout_d = 1'b1;
                        release_bus = 1'b1;
                    end else begin
                        state_d  = S_HI;
                        start_hi = 1'b1;
                    end
`else
                    state_d  = S_HI;
                    start_hi = 1'b1;
`endif
                end else if (write_q && (cnt_q == LAST_CNT - 3'd1)) begin
                    we_n_d = 1'b1;
                end
            end
            S_HI: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_CNT) begin
                    if (!write_q) begin
                        hrdata_d[31:16] = SRAM_DQ_i;
                    end
                    state_d     = S_DONE;
                    hreadyout_d = 1'b1;
                    release_bus = 1'b1;
                end else if (write_q && (cnt_q == LAST_CNT - 3'd1)) begin
                    we_n_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                hreadyout_d = 1'b1;
                release_bus = 1'b1;
            end
        endcase

        // Launch a halfword access; write data comes from wdata_d so the
        // LATCH cycle can forward HWDATA straight into the low half.
        if (start_lo || start_hi) begin
            addr_d = {word_q, start_hi};
            cnt_d  = 3'd0;
            ce_n_d = 1'b0;
            if (write_q) begin
                oe_n_d  = 1'b1;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                dq_o_d  = start_hi ? wdata_d[31:16] : wdata_d[15:0];
                ub_n_d  = start_hi ? ~strb_d[3] : ~strb_d[1];
                lb_n_d  = start_hi ? ~strb_d[2] : ~strb_d[0];
            end else begin
                oe_n_d  = 1'b0;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
                ub_n_d  = 1'b0;
                lb_n_d  = 1'b0;
            end
        end

        // Deselect the SRAM; address and data are left where they were.
        if (release_bus) begin
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            ub_n_d  = 1'b1;
            lb_n_d  = 1'b1;
            dq_oe_d = 1'b0;
        end
    end

    // State and registered outputs; reset releases the SRAM immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            word_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= 32'd0;
            strb_q      <= 4'd0;
            hrdata_q    <= 32'd0;
            hreadyout_q <= 1'b1;
            addr_q      <= '0;
            dq_o_q      <= 16'd0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            addr_q      <= addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
        end
    end

    assign bus.HRDATA    = hrdata_q;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = 1'b0;

    assign SRAM_ADDR  = addr_q;
    assign SRAM_DQ_o  = dq_o_q;
    assign SRAM_DQ_oe = dq_oe_q;
    assign SRAM_CE_N  = ce_n_q;
    assign SRAM_OE_N  = oe_n_q;
    assign SRAM_WE_N  = we_n_q;
    assign SRAM_UB_N  = ub_n_q;
    assign SRAM_LB_N  = lb_n_q;
endmodule

// File: tb/tb_ahb_sram16_resp.sv
// tb/tb_ahb_sram16_resp.sv - directed bench for ahb_sram16_resp with a behavioural 16-bit SRAM
module tb_ahb_sram16_resp;
    localparam int AW = 21;

    logic          clk;
    logic          reset;
    logic          hready_en;
    logic [AW-2:0] sram_addr;
    logic [15:0]   sram_dq_o;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_i;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int total = 0;
    int bad   = 0;

    ahb_sram16_resp_if #(.ADDR_WIDTH(AW)) ahb ();

    assign ahb.HREADY = ahb.HREADYOUT & hready_en;

    ahb_sram16_resp #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (ahb),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ_o  (sram_dq_o),
        .SRAM_DQ_oe (sram_dq_oe),
        .SRAM_DQ_i  (sram_dq_i),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM plus activity counters and a write log
    logic [15:0] mem [0:511];
    int          ce_cnt = 0;
    int          oe_cnt = 0;
    int          wn     = 0;
    logic [19:0] wl_addr [0:63];
    logic [15:0] wl_data [0:63];
    logic        wl_ub   [0:63];
    logic        wl_lb   [0:63];

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[8:0]] : 16'h0000;

    always @(negedge clk) begin
        if (!sram_ce_n) ce_cnt = ce_cnt + 1;
        if (!sram_ce_n && !sram_oe_n) oe_cnt = oe_cnt + 1;
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) mem[sram_addr[8:0]][7:0]  = sram_dq_o[7:0];
            if (!sram_ub_n) mem[sram_addr[8:0]][15:8] = sram_dq_o[15:8];
            if (wn < 64) begin
                wl_addr[wn] = sram_addr;
                wl_data[wn] = sram_dq_o;
                wl_ub[wn]   = sram_ub_n;
                wl_lb[wn]   = sram_lb_n;
            end
            wn = wn + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int xfer_ce, xfer_oe, xfer_w0;

    // One isolated transfer; caller is at a negedge with HREADYOUT=1.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, output int lat);
        int ce0, oe0;
        ahb.HSEL   = 1'b1;
        ahb.HADDR  = addr[AW-1:0];
        ahb.HTRANS = 2'b10;
        ahb.HWRITE = wr;
        @(posedge clk);
        #1;
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = 2'b00;
        ahb.HWDATA = wd;
        ahb.HWSTRB = st;
        ce0 = ce_cnt;
        oe0 = oe_cnt;
        xfer_w0 = wn;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ahb.HREADYOUT && lat < 40);
        xfer_ce = ce_cnt - ce0;
        xfer_oe = oe_cnt - oe0;
    endtask

    logic [31:0] bexp [0:3];

    initial begin
        int lat;
        int beat, cyc, guard, k;
        int exp_lat, exp_ce, exp_wn;

        reset      = 1'b1;
        hready_en  = 1'b1;
        ahb.HSEL   = 1'b0;
        ahb.HADDR  = '0;
        ahb.HTRANS = 2'b00;
        ahb.HWRITE = 1'b0;
        ahb.HWDATA = 32'd0;
        ahb.HWSTRB = 4'd0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
        chk("rst_hrdata", ahb.HRDATA, 32'd0);
        chk("rst_hresp", 32'(ahb.HRESP), 32'd0);
        chk("rst_ctrl_n", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1f);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_o", 32'(sram_dq_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full word write
        do_xfer(32'h100, 1'b1, 32'hDEADBEEF, 4'b1111, lat);
        chk("wr_lat", lat, 6);
        chk("wr_nwe", wn - xfer_w0, 2);
        chk("wr_addr0", 32'(wl_addr[xfer_w0]), 32'h80);
        chk("wr_data0", 32'(wl_data[xfer_w0]), 32'hBEEF);
        chk("wr_addr1", 32'(wl_addr[xfer_w0+1]), 32'h81);
        chk("wr_data1", 32'(wl_data[xfer_w0+1]), 32'hDEAD);
        chk("wr_ublb0", 32'({wl_ub[xfer_w0], wl_lb[xfer_w0]}), 32'd0);

        // Read it back
        do_xfer(32'h100, 1'b0, 32'd0, 4'b0000, lat);
        chk("rd_lat", lat, 6);
        chk("rd_data", ahb.HRDATA, 32'hDEADBEEF);
        chk("rd_oe_cycles", xfer_oe, 4);
        chk("rd_hresp", 32'(ahb.HRESP), 32'd0);

        // Single byte write in the upper lane
`ifdef SRAM_STRB_SKIP_EN
        exp_lat = 4; exp_ce = 2; exp_wn = 1;
`else
        exp_lat = 6; exp_ce = 4; exp_wn = 2;
`endif
        do_xfer(32'h103, 1'b1, 32'hAA000000, 4'b1000, lat);
        chk("bw_lat", lat, exp_lat);
        chk("bw_ce_cycles", xfer_ce, exp_ce);
        chk("bw_nwe", wn - xfer_w0, exp_wn);
        chk("bw_addr", 32'(wl_addr[wn-1]), 32'h81);
        chk("bw_ub_lb", 32'({wl_ub[wn-1], wl_lb[wn-1]}), 32'b01);
        chk("bw_data_hi", 32'(wl_data[wn-1][15:8]), 32'hAA);
        do_xfer(32'h100, 1'b0, 32'd0, 4'b0000, lat);
        chk("bw_readback", ahb.HRDATA, 32'hAAADBEEF);

        // Fill 0x200..0x20C, then read it as a 4-beat INCR burst
        bexp[0] = 32'h11112222;
        bexp[1] = 32'h33334444;
        bexp[2] = 32'h55556666;
        bexp[3] = 32'h77778888;
        for (int i = 0; i < 4; i++) begin
            do_xfer(32'h200 + 32'(4 * i), 1'b1, bexp[i], 4'b1111, lat);
        end
        ahb.HSEL   = 1'b1;
        ahb.HADDR  = AW'(32'h200);
        ahb.HTRANS = 2'b10;
        ahb.HWRITE = 1'b0;
        beat = 0; cyc = 0; guard = 0;
        while (beat < 4 && guard < 100) begin
            @(negedge clk);
            guard++;
            cyc++;
            if (ahb.HREADYOUT) begin
                chk($sformatf("burst_data%0d", beat), ahb.HRDATA, bexp[beat]);
                chk($sformatf("burst_lat%0d", beat), cyc, 6);
                chk($sformatf("burst_hresp%0d", beat), 32'(ahb.HRESP), 32'd0);
                beat++;
                cyc = 0;
                if (beat < 4) begin
                    ahb.HADDR  = AW'(32'h200 + 32'(4 * beat));
                    ahb.HTRANS = 2'b11;
                end else begin
                    ahb.HTRANS = 2'b00;
                    ahb.HSEL   = 1'b0;
                end
            end
        end
        chk("burst_beats", beat, 4);

        // IDLE, BUSY, and NONSEQ without HREADY: no SRAM activity
        k = ce_cnt;
        ahb.HSEL   = 1'b1;
        ahb.HADDR  = AW'(32'h100);
        ahb.HTRANS = 2'b00;
        @(negedge clk);
        chk("idle_ce_n", 32'(sram_ce_n), 32'd1);
        chk("idle_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
        ahb.HTRANS = 2'b01;
        @(negedge clk);
        chk("busy_ce_n", 32'(sram_ce_n), 32'd1);
        chk("busy_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
        hready_en  = 1'b0;
        ahb.HTRANS = 2'b10;
        @(negedge clk);
        ahb.HTRANS = 2'b00;
        hready_en  = 1'b1;
        @(negedge clk);
        chk("nordy_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
        chk("nordy_hresp", 32'(ahb.HRESP), 32'd0);
        chk("no_access_ce_cycles", ce_cnt - k, 0);
        ahb.HSEL = 1'b0;

        // Reset during the low-half write pulse
        do_xfer(32'h300, 1'b1, 32'hCAFEF00D, 4'b1111, lat);
        ahb.HSEL   = 1'b1;
        ahb.HADDR  = AW'(32'h300);
        ahb.HTRANS = 2'b10;
        ahb.HWRITE = 1'b1;
        @(posedge clk);
        #1;
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = 2'b00;
        ahb.HWDATA = 32'h12345678;
        ahb.HWSTRB = 4'b1111;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (sram_we_n && k < 20);
        chk("mid_we_low_cycle", k, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        chk("mid_rst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("mid_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("mid_rst_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_xfer(32'h300, 1'b0, 32'd0, 4'b0000, lat);
        chk("mid_rst_hi_kept", 32'(ahb.HRDATA[31:16]), 32'hCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ahb_sram16_resp.md
Name: ahb_sram16_resp

Overview:
- AHB-Lite responder (subordinate) for the EXT_MEM region; the completing end of the core's AHB initiator.
- Converts each 32-bit AHB transfer into one or two accesses on the board's 16-bit asynchronous SRAM.
- Sits behind the uncore address decoder. Inserts wait states via HREADYOUT; supports back-to-back and burst (INCR/WRAP) beats as individual pipelined transfers.

Parameters:
- ADDR_WIDTH, 21: byte-address bits decoded (2 MiB SRAM); SRAM halfword address is HADDR[ADDR_WIDTH-1:1].
- WAIT_STATES, 1: extra cycles per 16-bit SRAM access (access length N = WAIT_STATES+1); legal range 1..7.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- HSEL  in  1  region select from decoder
- HADDR  in  ADDR_WIDTH  address-phase byte address
- HTRANS  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ)
- HWRITE  in  1  write when 1
- HREADY  in  1  bus-level ready (address phase qualifier)
- HWDATA  in  32  write data, valid in data phase
- HWSTRB  in  4  byte strobes, valid in data phase
- HRDATA  out  32  read data, valid when HREADYOUT=1 at end of a read
- HREADYOUT  out  1  responder ready
- HRESP  out  1  always 0 (OKAY)
- SRAM_ADDR  out  ADDR_WIDTH-1  halfword address
- SRAM_DQ_o  out  16  write data to pad
- SRAM_DQ_oe  out  1  pad output enable
- SRAM_DQ_i  in  16  read data from pad
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls

Behaviour:
- Reset values (async, immediate):
  - SRAM_CE_N=OE_N=WE_N=UB_N=LB_N=1, SRAM_DQ_oe=0, SRAM_ADDR=0, SRAM_DQ_o=0.
  - HREADYOUT=1, HRDATA=0, HRESP=0, FSM=IDLE.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. Latch HADDR[ADDR_WIDTH-1:2] and HWRITE.
- Accepted while BUSY/IDLE or HSEL=0: no action; HREADYOUT stays 1 (zero-wait OKAY).
- FSM: IDLE -> LATCH -> LO -> HI -> DONE -> IDLE.
  - LATCH (1 cycle): capture HWDATA/HWSTRB for writes; reads pass straight through.
  - LO: low halfword, address {word,0}, N cycles.
  - HI: high halfword, address {word,1}, N cycles.
  - DONE: HREADYOUT=1. A new accepted address phase in DONE goes directly to LATCH (no IDLE bubble).
- HREADYOUT=0 in LATCH, LO and HI; it is 1 in IDLE and DONE.
- All SRAM outputs are registered: stable and glitch-free for the whole N-cycle access.
- Read access: CE_N=0, OE_N=0, UB_N=LB_N=0 for N cycles; DQ sampled on the last cycle into HRDATA[15:0] (LO) or HRDATA[31:16] (HI).
- Write access: DQ_oe=1 and data driven all N cycles. WE_N=0 on cycles 1..N-1 and 1 on the last cycle (data hold). UB_N/LB_N = ~strobes for that half.
- Latency, data phase to HREADYOUT=1: 2N+2 cycles (LATCH + LO + HI + DONE). WAIT_STATES=1 gives 6.
- Reads always perform both halves regardless of HSIZE.
- HRDATA holds its last value until the next read completes.
- Reset mid-access: SRAM released the same cycle, no partial write completion required.

Optional Feature:
- Macro SRAM_STRB_SKIP_EN.
- When defined: a write half whose strobes are both 0 is skipped (LO/HI bypassed), giving N+2 latency for single-half writes. A write with HWSTRB=0000 goes LATCH->DONE in 2 cycles.
- When undefined: every write performs both halves; halves with zero strobes are still cycled with UB_N=LB_N=1, so no bytes change.

Test Plan:
- Reset asserted mid-write (WE_N=0) -> same cycle WE_N=1, CE_N=1, DQ_oe=0, HREADYOUT=1; the other untouched half of the word keeps its prior value.
- Word write 0xDEADBEEF, HWSTRB=1111, HADDR=0x100, WAIT_STATES=1:
  - SRAM sees addr 0x80 data 0xBEEF, then addr 0x81 data 0xDEAD, WE_N low one cycle each.
  - HREADYOUT=1 on data-phase cycle 6.
- Read back from 0x100 -> HRDATA=0xDEADBEEF with HREADYOUT=1 after 6 cycles; OE_N low 4 cycles total.
- Byte write 0xAA at HADDR=0x103, HWSTRB=1000:
  - With SRAM_STRB_SKIP_EN: only addr 0x81 accessed, UB_N=0, LB_N=1, latency 4; readback 0xAAADBEEF.
  - Without the macro: latency 6, same readback.
- Four-beat INCR read burst at 0x200..0x20C, HTRANS NONSEQ,SEQ,SEQ,SEQ -> four OKAY beats, each 6 cycles, no IDLE gap between DONE and next LATCH, correct data per beat.
- HTRANS=IDLE and BUSY with HSEL=1, plus NONSEQ with HREADY=0 -> no SRAM activity (CE_N=1), HREADYOUT stays 1, HRESP=0.
